y86_dmem_responder: RTL

Responder end of the memory-stage data access interface. Accepts one 8-byte read or write request at a time from the pipeline's memory stage over a valid/ready handshake. It services the request from an internal byte-addressed array after a fixed latency and returns data plus an error flag over a second valid/ready handshake. A byte-wide preload port fills the array before a program runs.

---
 rtl/y86_mem_pkg.sv | 24 ++
 rtl/y86_byte_ram.sv | 41 ++++
 rtl/y86_dmem_responder.sv | 125 ++++++++++++
 3 files changed

// File: rtl/y86_mem_pkg.sv
// Shared definitions for the Y86 memory-stage data interface.
// Status codes follow the Y86 stage status encoding.
package y86_mem_pkg;

    localparam int unsigned WORD_BYTES = 8;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } dmem_state_t;

    typedef enum logic [2:0] {
        STAT_AOK = 3'd1,
        STAT_HLT = 3'd2,
        STAT_ADR = 3'd3,
        STAT_INS = 3'd4
    } stat_t;

    function automatic stat_t dmem_status(input logic error);
        return error ? STAT_ADR : STAT_AOK;
    endfunction

endpackage

// File: rtl/y86_byte_ram.sv
// Byte-addressed array with an 8-byte little-endian read/write port and a
// single-byte preload port; the word write overrides a preload to the same byte.
module y86_byte_ram
    import y86_mem_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 1024,
    localparam int unsigned AW = $clog2(MEM_BYTES)
) (
    input  logic          clk,
    input  logic [AW-1:0] rd_addr,
    output logic [63:0]   rd_data,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [63:0]   wr_data,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [7:0]    ld_byte
);

    logic [7:0] mem [MEM_BYTES];

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < WORD_BYTES; i++) begin
            rd_data[8*i +: 8] = mem[rd_addr + AW'(i)];
        end
    end

    // Word write is issued after the preload so it wins on a shared byte.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_byte;
        end
        if (wr_en) begin
            for (int i = 0; i < WORD_BYTES; i++) begin
                mem[wr_addr + AW'(i)] <= wr_data[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/y86_dmem_responder.sv
// Memory-stage data responder: one outstanding 8-byte request, fixed latency,
// 64-bit range check, response held until the requester takes it.
module y86_dmem_responder
    import y86_mem_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 1024,
    parameter int unsigned LATENCY   = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_write,
    input  logic [63:0]                  req_addr,
    input  logic [63:0]                  req_wdata,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [63:0]                  rsp_rdata,
    output logic                         rsp_error,
    input  logic                         ld_en,
    input  logic [$clog2(MEM_BYTES)-1:0] ld_addr,
    input  logic [7:0]                   ld_byte
);

    localparam int unsigned AW = $clog2(MEM_BYTES);
    localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);
    localparam logic [63:0] MAX_ADDR = 64'(MEM_BYTES - WORD_BYTES);

    dmem_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          write_q, write_d;
    logic [63:0]   addr_q, addr_d;
    logic [63:0]   wdata_q, wdata_d;
    logic [63:0]   rdata_q, rdata_d;
    logic          error_q, error_d;

    logic          access;
    logic          addr_err;
    logic          ram_wr_en;
    logic [63:0]   ram_rdata;

    // Full-width compare so addresses near 2^64 cannot alias into the array.
    assign addr_err  = addr_q > MAX_ADDR;
    assign access    = (state_q == BUSY) && (cnt_q == '0);
    assign ram_wr_en = access && write_q && !addr_err && rst_n;

    y86_byte_ram #(
        .MEM_BYTES(MEM_BYTES)
    ) u_ram (
        .clk    (clk),
        .rd_addr(addr_q[AW-1:0]),
        .rd_data(ram_rdata),
        .wr_en  (ram_wr_en),
        .wr_addr(addr_q[AW-1:0]),
        .wr_data(wdata_q),
        .ld_en  (ld_en),
        .ld_addr(ld_addr),
        .ld_byte(ld_byte)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        error_d = error_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = CNT_INIT;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    error_d = addr_err;
                    rdata_d = (write_q || addr_err) ? 64'd0 : ram_rdata;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rdata_d = '0;
                    error_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            error_q <= error_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_error = error_q;

endmodule
